// File: rtl/handshake_fifo_opaque_pkg.sv
// Shared constants, the occupancy-update encoding and a constant-safe clog2
// used by the elastic FIFO stage and its pointer counters.
package handshake_fifo_opaque_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_DEPTH      = 4;

    // Encoded as {push, pop} so it can be built directly from the two handshakes.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/handshake_fifo_opaque_wrap_counter.sv
// Modulo-MAX pointer counter: advances on en and wraps MAX-1 -> 0 by explicit
// compare, so MAX need not be a power of two.
module handshake_wrap_counter
    import handshake_fifo_opaque_pkg::*;
#(
    parameter  int MAX = 4,
    localparam int W   = (clog2(MAX) < 1) ? 1 : clog2(MAX)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] value
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (en) begin
            value_d = (value_q == W'(MAX - 1)) ? '0 : value_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/handshake_fifo_opaque.sv
// Opaque elastic FIFO stage: both flags are registered from occupancy, so no
// combinational valid or ready path crosses the stage.
module handshake_fifo_opaque
    import handshake_fifo_opaque_pkg::*;
#(
    parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter  int DEPTH      = DEFAULT_DEPTH,
    localparam int CNT_W      = clog2(DEPTH + 1),
    localparam int PTR_W      = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready,
    output logic [CNT_W-1:0]      count
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count_q,      count_d;
    logic                  ins_ready_q,  ins_ready_d;
    logic                  outs_valid_q, outs_valid_d;
    logic                  push;
    logic                  pop;
    fifo_op_e              op;

    assign push = ins_valid & ins_ready_q;
    assign pop  = outs_valid_q & outs_ready;
    assign op   = fifo_op_e'({push, pop});

    handshake_wrap_counter #(.MAX(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst),
        .en    (push),
        .value (wr_ptr)
    );

    handshake_wrap_counter #(.MAX(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst),
        .en    (pop),
        .value (rd_ptr)
    );

    // Flags look at next occupancy so they line up with count_q after the edge.
    always_comb begin
        count_d = count_q;
        case (op)
            OP_PUSH: count_d = count_q + 1'b1;
            OP_POP:  count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ins_ready_d  = (count_d != CNT_W'(DEPTH));
        outs_valid_d = (count_d != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q      <= '0;
            ins_ready_q  <= 1'b0;
            outs_valid_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            ins_ready_q  <= ins_ready_d;
            outs_valid_q <= outs_valid_d;
        end
    end

    // Storage carries no reset; the cleared count keeps stale words invisible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr] <= ins;
        end
    end

    assign ins_ready  = ins_ready_q;
    assign outs_valid = outs_valid_q;
    assign outs       = outs_valid_q ? mem_q[rd_ptr] : '0;
    assign count      = count_q;

    // Upstream must not withdraw or alter a word the stage has not yet taken.
    hold_while_stalled: assert property (
        @(posedge clk) disable iff (!rst)
        (ins_valid && !ins_ready_q) |=> (ins_valid && $stable(ins))
    );

endmodule
